instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/hack_pkg.sv | 14 +
 rtl/pc_reg.sv | 38 +++
 rtl/instr_fetch.sv | 77 +++++++
 3 files changed

// File: rtl/hack_pkg.sv
// Shared constants for the fetch front end.
//   WORD_W            - instruction / address word width
//   ROM_DEPTH_DEFAULT - default number of instruction words
//   RESET_PC_DEFAULT  - default first fetch address after reset
package hack_pkg;
  localparam int          WORD_W            = 16;
  localparam int          ROM_DEPTH_DEFAULT = 1024;
  localparam logic [15:0] RESET_PC_DEFAULT  = 16'h0000;

  // Address mask for a power-of-two ROM depth (<= 65536).
  function automatic logic [WORD_W-1:0] addr_mask(input int depth);
    return WORD_W'(depth - 1);
  endfunction
endpackage

// File: rtl/pc_reg.sv
// Program counter register.
//   clk, rst_n : clock, async active-low reset (PC <= RESET_PC)
//   load       : take load_val (masked to ROM_DEPTH), highest priority
//   load_val   : redirect target
//   inc        : advance PC by one, wrapping at ROM_DEPTH
//   hold       : keep PC; overrides inc
//   pc         : current PC, upper bits beyond log2(ROM_DEPTH) always 0
module pc_reg
  import hack_pkg::*;
#(
  parameter int          ROM_DEPTH = ROM_DEPTH_DEFAULT,
  parameter logic [15:0] RESET_PC  = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WORD_W-1:0] load_val,
  input  logic              inc,
  input  logic              hold,
  output logic [WORD_W-1:0] pc
);
  localparam logic [WORD_W-1:0] MASK = addr_mask(ROM_DEPTH);

  logic [WORD_W-1:0] pc_d, pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load)              pc_d = load_val & MASK;
    else if (inc && !hold) pc_d = (pc_q + 1'b1) & MASK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC & MASK;
    else        pc_q <= pc_d;
  end

  assign pc = pc_q;
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: drives a combinational ROM with the PC and
// registers one instruction into a valid/ready output slot.
//   clk, rst_n              : clock, async active-low reset
//   rom_addr / rom_data     : ROM address (== PC) and same-cycle ROM word
//   jump, jump_addr         : redirect; beats stall and fetch, drops slot
//   stall                   : inhibit new fetches
//   instr, instr_pc         : registered instruction and its address
//   instr_valid/instr_ready : output handshake
module instr_fetch
  import hack_pkg::*;
#(
  parameter int          ROM_DEPTH = ROM_DEPTH_DEFAULT,
  parameter logic [15:0] RESET_PC  = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [WORD_W-1:0] rom_addr,
  input  logic [WORD_W-1:0] rom_data,
  input  logic              jump,
  input  logic [WORD_W-1:0] jump_addr,
  input  logic              stall,
  output logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready
);
  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] instr_d, instr_q, instr_pc_d, instr_pc_q;
  logic              valid_d, valid_q;
  logic              hs, slot_free, fetch;

  assign hs        = valid_q & instr_ready;
  assign slot_free = ~valid_q | hs;
  assign fetch     = ~jump & ~stall & slot_free;

  pc_reg #(.ROM_DEPTH(ROM_DEPTH), .RESET_PC(RESET_PC)) u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (jump),
    .load_val (jump_addr),
    .inc      (fetch),
    .hold     (~fetch),
    .pc       (pc)
  );

  always_comb begin
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    if (jump) begin
      valid_d = 1'b0;               // discard any unconsumed word
    end else if (stall) begin
      if (hs) valid_d = 1'b0;       // slot drains, nothing refills it
    end else if (slot_free) begin
      instr_d    = rom_data;
      instr_pc_d = pc;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
    end
  end

  assign rom_addr    = pc;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;
endmodule
